// File: rtl/r22sdf_ctrl.sv
`default_nettype none
// ============================================================================
// r22sdf_ctrl : sequencer for an R2^2 SDF FFT pipeline (counter, stage
//               controls, enable, output flags, end-of-stream drain).
//               Optional drain logic is built when FFT_CTRL_FLUSH_EN is defined.
// Revision    : 1.0
// ============================================================================
module r22sdf_ctrl #(
    parameter int N_POINTS   = 16,
    parameter int PIPE_REGS  = 0,
    parameter int FLUSH_WAIT = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid_i,
    input  logic                            in_sop_i,
    output logic                            in_ready_o,
    output logic                            en_o,
    output logic [$clog2(N_POINTS)/2-1:0]   bf1_ctrl_o,
    output logic [$clog2(N_POINTS)/2-1:0]   bf2_ctrl_o,
    output logic [$clog2(N_POINTS)/2-1:0]   bf2_negj_o,
    output logic                            out_valid_o,
    output logic                            out_sop_o,
    output logic                            out_eop_o,
    output logic                            sop_err_o,
    output logic                            busy_o
);

    localparam int LOG2N   = $clog2(N_POINTS);
    localparam int S       = LOG2N / 2;
    localparam int LATENCY = N_POINTS - 1 + 2 * S * PIPE_REGS;
    localparam int FW      = $clog2(LATENCY + 1);

    localparam logic [FW-1:0]    FILL_MAX = FW'(LATENCY);
    localparam logic [LOG2N-1:0] LAT_MOD  = LOG2N'(LATENCY);
    localparam logic [LOG2N-1:0] CNT_LAST = LOG2N'(N_POINTS - 1);

    if (N_POINTS < 16 || (1 << LOG2N) != N_POINTS || (LOG2N % 2) != 0 ||
        FLUSH_WAIT < 1 || PIPE_REGS < 0) begin : g_bad_cfg
        $error("r22sdf_ctrl: unsupported parameter set");
    end

`ifdef FFT_CTRL_FLUSH_EN
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FLUSH} state_e;

    localparam int WW = $clog2(FLUSH_WAIT + 1);
    localparam logic [WW-1:0] WAIT_LAST  = WW'(FLUSH_WAIT - 1);
    localparam logic [FW-1:0] DRAIN_LAST = FW'(LATENCY - 1);

    logic [WW-1:0] wait_q, wait_d;
    logic [FW-1:0] drain_q, drain_d;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_RUN} state_e;
`endif

    state_e           state_q, state_d;
    logic [LOG2N-1:0] cnt_q, cnt_d;
    logic [FW-1:0]    fill_q, fill_d;

    logic             w_acc;
    logic             w_en;
    logic             w_sop_err;
    logic [LOG2N-1:0] w_out_idx;

`ifdef FFT_CTRL_FLUSH_EN
    assign in_ready_o = (state_q != ST_FLUSH);
    assign w_en       = w_acc | (state_q == ST_FLUSH);
`else
    assign in_ready_o = 1'b1;
    assign w_en       = w_acc;
`endif

    assign w_acc     = in_valid_i & in_ready_o;
    assign w_sop_err = (state_q == ST_RUN) & w_acc & in_sop_i & (cnt_q != '0);
    assign w_out_idx = cnt_q - LAT_MOD;

    assign en_o        = w_en;
    assign sop_err_o   = w_sop_err;
    assign busy_o      = (state_q != ST_IDLE);
    assign out_valid_o = w_en & (fill_q == FILL_MAX);
    assign out_sop_o   = out_valid_o & (w_out_idx == '0);
    assign out_eop_o   = out_valid_o & (w_out_idx == CNT_LAST);

    // Stage k sees the sample 2*k*PIPE_REGS slots behind stage 0.
    for (genvar k = 0; k < S; k++) begin : g_stage
        logic [LOG2N-1:0] w_c;
        logic [1:0]       w_pair;
        assign w_c            = cnt_q - LOG2N'(2 * k * PIPE_REGS);
        assign w_pair         = 2'(w_c >> (LOG2N - 2 - 2 * k));
        assign bf1_ctrl_o[k]  = w_pair[1];
        assign bf2_ctrl_o[k]  = w_pair[0];
        assign bf2_negj_o[k]  = w_pair[1] & ~w_pair[0];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fill_d  = fill_q;
`ifdef FFT_CTRL_FLUSH_EN
        wait_d  = wait_q;
        drain_d = drain_q;
`endif
        if (w_en) begin
            // A misaligned sop restarts the frame; fill restarts so stale
            // samples already in the chain are never flagged as real.
            if (w_sop_err) begin
                cnt_d  = LOG2N'(1);
                fill_d = FW'(1);
            end else begin
                cnt_d = cnt_q + LOG2N'(1);
                if (fill_q != FILL_MAX) begin
                    fill_d = fill_q + FW'(1);
                end
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (w_acc) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
`ifdef FFT_CTRL_FLUSH_EN
                if (w_acc) begin
                    wait_d = '0;
                end else if (cnt_q == '0) begin
                    if (wait_q == WAIT_LAST) begin
                        state_d = ST_FLUSH;
                        wait_d  = '0;
                        drain_d = '0;
                    end else begin
                        wait_d = wait_q + WW'(1);
                    end
                end
`endif
            end
`ifdef FFT_CTRL_FLUSH_EN
            ST_FLUSH: begin
                drain_d = drain_q + FW'(1);
                if (drain_q == DRAIN_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    fill_d  = '0;
                    drain_d = '0;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            fill_q  <= '0;
`ifdef FFT_CTRL_FLUSH_EN
            wait_q  <= '0;
            drain_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fill_q  <= fill_d;
`ifdef FFT_CTRL_FLUSH_EN
            wait_q  <= wait_d;
            drain_q <= drain_d;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_r22sdf_ctrl.sv
`default_nettype none
// ============================================================================
// tb_r22sdf_ctrl : scoreboard bench for r22sdf_ctrl (N_POINTS=16, PIPE_REGS=0)
// Revision       : 1.0
// ============================================================================
module tb_r22sdf_ctrl;

    localparam int N   = 16;
    localparam int LAT = 15;
`ifdef FFT_CTRL_FLUSH_EN
    localparam int A_OV  = 16;
    localparam int A_EOP = 1;
`else
    localparam int A_OV  = 1;
    localparam int A_EOP = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_sop;
    logic       in_ready;
    logic       en;
    logic [1:0] bf1;
    logic [1:0] bf2;
    logic [1:0] negj;
    logic       out_valid;
    logic       out_sop;
    logic       out_eop;
    logic       sop_err;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;
    int en_seen = 0;
    int ov_seen = 0;
    int sop_seen = 0;
    int eop_seen = 0;
    int err_seen = 0;

    logic [9:0] sb[$];
    logic [9:0] mon_exp;
    int         ecnt  = 0;
    int         prior = 0;

    r22sdf_ctrl #(.N_POINTS(16), .PIPE_REGS(0), .FLUSH_WAIT(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (in_valid),
        .in_sop_i    (in_sop),
        .in_ready_o  (in_ready),
        .en_o        (en),
        .bf1_ctrl_o  (bf1),
        .bf2_ctrl_o  (bf2),
        .bf2_negj_o  (negj),
        .out_valid_o (out_valid),
        .out_sop_o   (out_sop),
        .out_eop_o   (out_eop),
        .sop_err_o   (sop_err),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected response of one en cycle, derived from the frame index rules.
    task automatic push_en(input logic bad);
        logic [3:0] c;
        logic [3:0] idx;
        logic [1:0] b1;
        logic [1:0] b2;
        logic       ov;
        c   = 4'(ecnt);
        b1  = {c[1], c[3]};
        b2  = {c[0], c[2]};
        ov  = (prior >= LAT);
        idx = c - 4'(LAT);
        sb.push_back({b1, b2, b1 & ~b2, ov, ov && (idx == 4'd0), ov && (idx == 4'd15), bad});
        if (bad) begin
            ecnt  = 1;
            prior = 1;
        end else begin
            ecnt  = (ecnt + 1) % N;
            prior = prior + 1;
        end
    endtask

    task automatic send(input logic sop);
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_sop   = sop;
        push_en(sop && (ecnt != 0));
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            in_sop   = 1'b0;
            @(negedge clk);
            check("gap_en", en, 1'b0);
            check("gap_busy", busy, 1'b1);
            check("gap_in_ready", in_ready, 1'b1);
        end
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            in_sop   = 1'b0;
            push_en(1'b0);
            @(negedge clk);
            check("flush_in_ready", in_ready, 1'b0);
        end
    endtask

    task automatic drain_full();
        drain(LAT);
        ecnt  = 0;
        prior = 0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("post_flush_in_ready", in_ready, 1'b1);
        check("post_flush_busy", busy, 1'b0);
    endtask

    task automatic check_reset();
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_en", en, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_ctrl", {bf1, bf2, negj}, 6'd0);
        check("rst_out_flags", {out_valid, out_sop, out_eop}, 3'd0);
        check("rst_sop_err", sop_err, 1'b0);
    endtask

    task automatic clear_counts();
        ov_seen  = 0;
        sop_seen = 0;
        eop_seen = 0;
        err_seen = 0;
    endtask

    always @(negedge clk) begin
        if (!rst && en) begin
            en_seen++;
            if (out_valid) ov_seen++;
            if (out_sop)   sop_seen++;
            if (out_eop)   eop_seen++;
            if (sop_err)   err_seen++;
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL en_unexpected: got en=1 at pulse %0d expected no en", en_seen);
            end else begin
                mon_exp = sb.pop_front();
                check($sformatf("en_pulse_%0d", en_seen),
                      {bf1, bf2, negj, out_valid, out_sop, out_eop, sop_err}, mon_exp);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_sop   = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset();

        // Frame with a mid-frame stall after sample 5.
        clear_counts();
        for (int i = 0; i < 6; i++) send(i == 0);
        gap(3);
        check("stall_bf1_0", bf1[0], 1'b0);
        check("stall_bf2_0", bf2[0], 1'b1);
        for (int i = 6; i < 16; i++) send(1'b0);
        gap(4);
`ifdef FFT_CTRL_FLUSH_EN
        drain_full();
`endif
        @(posedge clk);
        check("A_out_valid_count", ov_seen, A_OV);
        check("A_out_sop_count", sop_seen, 1);
        check("A_out_eop_count", eop_seen, A_EOP);

        // Two frames, 3-cycle boundary gap: no flush in between.
        clear_counts();
        for (int i = 0; i < 16; i++) send(i == 0);
        gap(3);
        for (int i = 0; i < 16; i++) send(i == 0);
        gap(4);
`ifdef FFT_CTRL_FLUSH_EN
        drain_full();
`endif
        @(posedge clk);
        check("BC_out_valid_count", ov_seen, 32);
        check("BC_out_sop_count", sop_seen, 2);

        // Misaligned sop at index 5.
        clear_counts();
        for (int i = 0; i < 5; i++) send(i == 0);
        send(1'b1);
        for (int i = 0; i < 15; i++) send(1'b0);
        gap(4);
`ifdef FFT_CTRL_FLUSH_EN
        drain_full();
`endif
        @(posedge clk);
        check("D_sop_err_count", err_seen, 1);

        // Reset seven cycles into a flush.
        for (int i = 0; i < 16; i++) send(i == 0);
        gap(4);
`ifdef FFT_CTRL_FLUSH_EN
        drain(7);
`else
        gap(7);
`endif
        @(posedge clk); #1;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_sop   = 1'b0;
        @(posedge clk); #1;
        rst   = 1'b0;
        ecnt  = 0;
        prior = 0;
        @(negedge clk);
        check_reset();

        // Clean restart after the reset.
        clear_counts();
        for (int i = 0; i < 16; i++) send(i == 0);
        gap(4);
`ifdef FFT_CTRL_FLUSH_EN
        drain_full();
`endif
        @(posedge clk);
        check("F_out_valid_count", ov_seen, A_OV);
        check("F_out_sop_count", sop_seen, 1);
        check("sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
